// File: rtl/dpu_pkg.sv
// dpu_pkg: shared widths and types for the dpu arbiter slice.
// Lane layout is little-endian: lane i sits at the i-th slice of each bus.
package dpu_pkg;

  localparam int DPU_LANES = 4;
  localparam int FP16_W    = 16;
  localparam int INT4_W    = 4;

  localparam int DPU_FP16_BUS_W = DPU_LANES * FP16_W;
  localparam int DPU_INT4_BUS_W = DPU_LANES * INT4_W;

  typedef logic dpu_req_id_t;

endpackage

// File: rtl/dpu_tag_fifo.sv
// dpu_tag_fifo: in-order requester-ID FIFO for beats inside the dpu.
// Caller guarantees no push when full and no pop when empty.
module dpu_tag_fifo
  import dpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  dpu_req_id_t            push_id,
  input  logic                   pop,
  output dpu_req_id_t            head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  dpu_req_id_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push & ~pop) begin
        count <= count + 1'b1;
      end else if (pop & ~push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/dpu_arbiter.sv
// dpu_arbiter: round-robin share of one dpu between two streamers.
// Requester IDs ride an in-order tag FIFO to route results back.
module dpu_arbiter
  import dpu_pkg::*;
#(
  parameter int TAG_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [DPU_FP16_BUS_W-1:0]   req0_fp16,
  input  logic [DPU_INT4_BUS_W-1:0]   req0_int4,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [DPU_FP16_BUS_W-1:0]   req1_fp16,
  input  logic [DPU_INT4_BUS_W-1:0]   req1_int4,
  output logic                        rsp0_valid,
  input  logic                        rsp0_ready,
  output logic [FP16_W-1:0]           rsp0_fp16,
  output logic                        rsp1_valid,
  input  logic                        rsp1_ready,
  output logic [FP16_W-1:0]           rsp1_fp16,
  output logic                        dpu_in_valid,
  input  logic                        dpu_in_ready,
  output logic [DPU_FP16_BUS_W-1:0]   dpu_in_fp16,
  output logic [DPU_INT4_BUS_W-1:0]   dpu_in_int4,
  input  logic                        dpu_out_valid,
  output logic                        dpu_out_ready,
  input  logic [FP16_W-1:0]           dpu_out_fp16,
  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        err_orphan
);

  dpu_req_id_t prio;
  dpu_req_id_t g;
  dpu_req_id_t h;
  logic        both;
  logic        any;
  logic        tag_full;
  logic        tag_empty;
  logic        can_issue;
  logic        issue;
  logic        ret;
  logic        h_ready;
  logic        rsp_ok;

  assign both = req0_valid & req1_valid;
  assign any  = req0_valid | req1_valid;

  // Idle or in reset the mux parks on req0.
  assign g = ~rst & (both ? prio : req1_valid);

  assign can_issue    = ~tag_full & dpu_in_ready & ~rst;
  assign dpu_in_valid = any & ~tag_full & ~rst;
  assign req0_ready   = can_issue & ~g;
  assign req1_ready   = can_issue & g;
  assign dpu_in_fp16  = g ? req1_fp16 : req0_fp16;
  assign dpu_in_int4  = g ? req1_int4 : req0_int4;
  assign issue        = dpu_in_valid & dpu_in_ready;

  assign h_ready       = h ? rsp1_ready : rsp0_ready;
  assign rsp_ok        = dpu_out_valid & ~tag_empty & ~rst;
  assign rsp0_valid    = rsp_ok & ~h;
  assign rsp1_valid    = rsp_ok & h;
  assign dpu_out_ready = ~tag_empty & h_ready & ~rst;
  assign rsp0_fp16     = dpu_out_fp16;
  assign rsp1_fp16     = dpu_out_fp16;
  assign ret           = dpu_out_valid & dpu_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (issue) begin
      prio <= ~g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (dpu_out_valid & tag_empty) begin
      err_orphan <= 1'b1;
    end
  end

  dpu_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (issue),
    .push_id(g),
    .pop    (ret),
    .head   (h),
    .empty  (tag_empty),
    .full   (tag_full),
    .count  (outstanding)
  );

endmodule

// File: tb/tb_dpu_arbiter.sv
// tb_dpu_arbiter: vector table plus corner sequences with a
// behavioural dpu and per-requester result scoreboards.
module tb_dpu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [63:0] req0_fp16 = '0;
  logic [15:0] req0_int4 = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [63:0] req1_fp16 = '0;
  logic [15:0] req1_int4 = '0;
  logic        rsp0_valid;
  logic        rsp0_ready = 1'b1;
  logic [15:0] rsp0_fp16;
  logic        rsp1_valid;
  logic        rsp1_ready = 1'b1;
  logic [15:0] rsp1_fp16;
  logic        dpu_in_valid;
  logic        dpu_in_ready = 1'b1;
  logic [63:0] dpu_in_fp16;
  logic [15:0] dpu_in_int4;
  logic        dpu_out_valid;
  logic        dpu_out_ready;
  logic [15:0] dpu_out_fp16 = '0;
  logic [3:0]  outstanding;
  logic        err_orphan;

  logic        q_valid = 1'b0;
  logic        orphan_force = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] dpu_q [$];
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  int          order [$];
  int          rsp0_cnt = 0;
  logic        rsp1_seen = 1'b0;

  logic        rst_s = 1'b1;
  logic        fire_in = 1'b0;
  logic        fire_out = 1'b0;
  logic [63:0] in_fp = '0;
  logic [15:0] in_i4 = '0;

  localparam logic [63:0] ONE4 = {4{16'h3C00}};
  localparam logic [63:0] TWO4 = {4{16'h4000}};

  assign dpu_out_valid = orphan_force | q_valid;

  always #5 clk = ~clk;

  dpu_arbiter #(.TAG_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_fp16    (req0_fp16),
    .req0_int4    (req0_int4),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_fp16    (req1_fp16),
    .req1_int4    (req1_int4),
    .rsp0_valid   (rsp0_valid),
    .rsp0_ready   (rsp0_ready),
    .rsp0_fp16    (rsp0_fp16),
    .rsp1_valid   (rsp1_valid),
    .rsp1_ready   (rsp1_ready),
    .rsp1_fp16    (rsp1_fp16),
    .dpu_in_valid (dpu_in_valid),
    .dpu_in_ready (dpu_in_ready),
    .dpu_in_fp16  (dpu_in_fp16),
    .dpu_in_int4  (dpu_in_int4),
    .dpu_out_valid(dpu_out_valid),
    .dpu_out_ready(dpu_out_ready),
    .dpu_out_fp16 (dpu_out_fp16),
    .outstanding  (outstanding),
    .err_orphan   (err_orphan)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Integer-valued fp16 encode, |n| < 2048.
  function automatic logic [15:0] to_fp16(input int n);
    logic s;
    int   m;
    int   e;
    s = (n < 0);
    m = s ? -n : n;
    if (m == 0) return 16'h0000;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return {s, 5'(15 + e), 10'((m << (10 - e)) & 32'h3FF)};
  endfunction

  // Dot product for lanes holding 1.0 or 2.0; other lanes count as 0.
  function automatic logic [15:0] dot(input logic [63:0] f,
                                      input logic [15:0] w);
    int acc;
    int k;
    logic [15:0] fl;
    logic [3:0]  wl;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      fl = f[16*i +: 16];
      wl = w[4*i +: 4];
      k = (fl == 16'h3C00) ? 1 : (fl == 16'h4000) ? 2 : 0;
      acc += k * int'($signed(wl));
    end
    return to_fp16(acc);
  endfunction

  // Sample handshakes that fire on the coming edge.
  initial forever begin
    @(negedge clk);
    rst_s    = rst;
    fire_in  = dpu_in_valid & dpu_in_ready;
    fire_out = dpu_out_valid & dpu_out_ready;
    in_fp    = dpu_in_fp16;
    in_i4    = dpu_in_int4;
    if (fire_in | (req0_valid & req0_ready) | (req1_valid & req1_ready))
      check("issue_owner",
            (req0_valid & req0_ready) ^ (req1_valid & req1_ready),
            fire_in);
    if (req0_valid & req0_ready) begin
      exp0.push_back(dot(req0_fp16, req0_int4));
      order.push_back(0);
      check("issue0_data", {dpu_in_fp16[47:0], dpu_in_int4},
            {req0_fp16[47:0], req0_int4});
    end
    if (req1_valid & req1_ready) begin
      exp1.push_back(dot(req1_fp16, req1_int4));
      order.push_back(1);
      check("issue1_data", {dpu_in_fp16[47:0], dpu_in_int4},
            {req1_fp16[47:0], req1_int4});
    end
    if (rsp1_valid) rsp1_seen = 1'b1;
    if (rsp0_valid & rsp0_ready) begin
      rsp0_cnt++;
      check("rsp0_pending", exp0.size() != 0, 1);
      if (exp0.size() != 0) check("rsp0_data", rsp0_fp16, exp0.pop_front());
    end
    if (rsp1_valid & rsp1_ready) begin
      check("rsp1_pending", exp1.size() != 0, 1);
      if (exp1.size() != 0) check("rsp1_data", rsp1_fp16, exp1.pop_front());
    end
  end

  // Behavioural dpu: one-cycle latency, unbounded elastic queue.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_s) begin
      dpu_q.delete();
      exp0.delete();
      exp1.delete();
    end else begin
      if (fire_out && dpu_q.size() != 0) void'(dpu_q.pop_front());
      if (fire_in) dpu_q.push_back(dot(in_fp, in_i4));
    end
    q_valid      = (dpu_q.size() != 0);
    dpu_out_fp16 = (dpu_q.size() != 0) ? dpu_q[0] : 16'h0000;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    orphan_force = 1'b0;
    dpu_in_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((outstanding != 0 || q_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, n < 60, 1);
  endtask

  typedef struct packed {
    logic v0;
    logic v1;
    logic rdy;
    logic e_r0;
    logic e_r1;
    logic e_dv;
    logic e_sel;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int n;
    logic [15:0] i4;
    logic [63:0] fp;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state with both requesters presenting distinct data.
    req0_valid = 1'b1; req0_fp16 = ONE4; req0_int4 = 16'h1111;
    req1_valid = 1'b1; req1_fp16 = TWO4; req1_int4 = 16'h2222;
    @(negedge clk);
    check("rst_rdy", {req0_ready, req1_ready, dpu_in_valid}, 3'b000);
    check("rst_rsp", {rsp0_valid, rsp1_valid, dpu_out_ready}, 3'b000);
    check("rst_data", dpu_in_int4, 16'h1111);
    do_reset();
    @(negedge clk);
    check("rst_outst", outstanding, 0);
    check("rst_orphan", err_orphan, 0);

    // Single requester.
    rsp0_cnt = 0;
    rsp1_seen = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_fp16 = ONE4; req0_int4 = 16'h1111;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain("single");
    check("single_cnt", rsp0_cnt, 1);
    check("single_rsp1", rsp1_seen, 0);
    check("single_exp", to_fp16(4), 16'h4400);

    // Contention from a fresh pointer.
    do_reset();
    order.delete();
    req1_fp16 = ONE4;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain("rr");
    check("rr_len", order.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_order%0d", i),
            (order.size() > i) ? order[i] : 9, i % 2);

    // Combinational vector table.
    do_reset();
    req1_fp16 = TWO4;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      dpu_in_ready = tbl[i].rdy;
      @(negedge clk);
      fp = tbl[i].e_sel ? TWO4 : ONE4;
      i4 = tbl[i].e_sel ? 16'h2222 : 16'h1111;
      check($sformatf("vec%0d_ctl", i),
            {req0_ready, req1_ready, dpu_in_valid},
            {tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_dv});
      check($sformatf("vec%0d_data", i), {dpu_in_fp16, dpu_in_int4}, {fp, i4});
    end
    drain("vec");

    // Full: eight beats held in the dpu by rsp0 backpressure.
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1;
    req0_int4  = 16'h1234;
    n = 0;
    while (outstanding != 8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("full_reach", outstanding, 8);
    check("full_block", {req0_ready, dpu_in_valid}, 2'b00);
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("full_pop", {dpu_out_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_after", {outstanding, req0_ready}, {4'd7, 1'b1});
    drain("full");

    // Head belongs to req1 which stalls; req0 must not see it.
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    req1_valid = 1'b1;
    req1_int4  = 16'h3333;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("bp_ctl", {dpu_out_ready, rsp0_valid, rsp1_valid}, 3'b001);
    end
    drain("bp");

    // Orphan result.
    @(posedge clk); #1;
    orphan_force = 1'b1;
    @(negedge clk);
    check("orph_rdy", {dpu_out_ready, err_orphan}, 2'b00);
    @(posedge clk); #1;
    orphan_force = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("orph_sticky", err_orphan, 1);
    end

    // Reset with three beats in flight.
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("mid_outst", outstanding, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst", {outstanding, err_orphan, rsp0_valid, rsp1_valid},
          {4'd0, 3'b000});
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("mid_grant", {req0_ready, req1_ready}, 2'b10);
    drain("mid");

    check("sb_empty", {exp0.size() == 0, exp1.size() == 0}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
